// File: rtl/reg_share_pkg.sv
// Shared definitions for the register-share arbiter: FSM state encoding,
// default sizing and the round-robin winner search.
package reg_share_pkg;

    localparam int unsigned DefN  = 4;
    localparam int unsigned DefW  = 4;
    localparam int unsigned MaxN  = 8;
    localparam int unsigned PickW = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StAck   = 2'd2
    } state_e;

    // First set request bit searching upward from ptr, wrapping n-1 -> 0.
    // Only the low n bits of req are considered; returns 0 when none are set.
    function automatic logic [PickW-1:0] rr_pick(input logic [MaxN-1:0] req,
                                                 input logic [PickW-1:0] ptr,
                                                 input int unsigned n);
        logic [PickW-1:0] pick;
        logic             found;
        int unsigned      idx;
        logic [PickW-1:0] idx3;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxN; i++) begin
            idx  = (32'(ptr) + i) % n;
            idx3 = PickW'(idx);
            if (!found && (i < n) && req[idx3]) begin
                pick  = idx3;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg_load_en.sv
// W-bit storage register with asynchronous active-low reset and load enable.
module reg_load_en #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Capture i_d only when load is asserted; hold otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// Sequence per write: IDLE (pick winner) -> GRANT (load q) -> ACK (pulse ack).
// Optional burst hold: define REG_SHARE_LOCK_EN so that lock[w] held in ACK
// re-grants the same requester without re-arbitrating.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned W = DefW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [W-1:0]         q,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int unsigned OwnerW = $clog2(N);

    state_e            r_state;
    state_e            w_state_d;
    logic [N-1:0]      r_gnt;
    logic [N-1:0]      w_gnt_d;
    logic [N-1:0]      r_ack;
    logic [N-1:0]      w_ack_d;
    logic [OwnerW-1:0] r_owner;
    logic [OwnerW-1:0] w_owner_d;
    logic [OwnerW-1:0] r_ptr;
    logic [OwnerW-1:0] w_ptr_d;
    logic [OwnerW-1:0] w_ptr_next;
    logic [OwnerW-1:0] w_pick;
    logic [MaxN-1:0]   w_req_ext;
    logic [PickW-1:0]  w_ptr_ext;
    logic [PickW-1:0]  w_pick_ext;
    logic [N-1:0]      w_pick_oh;
    logic [N-1:0]      w_owner_oh;
    logic [W-1:0]      w_wdata;
    logic              w_any_req;
    logic              w_lock_hold;
    logic              w_load;
    logic              w_pick_unused;

    // Widen request vector and pointer to the package search width.
    always_comb begin
        w_req_ext            = '0;
        w_req_ext[N-1:0]     = req;
        w_ptr_ext            = '0;
        w_ptr_ext[OwnerW-1:0] = r_ptr;
    end

    assign w_any_req     = |req;
    assign w_pick_ext    = rr_pick(w_req_ext, w_ptr_ext, N);
    assign w_pick        = w_pick_ext[OwnerW-1:0];
    assign w_pick_unused = ^w_pick_ext;
    assign w_ptr_next    = (r_owner == OwnerW'(N - 1)) ? '0 : r_owner + 1'b1;

    // One-hot forms of the new winner and the current owner.
    always_comb begin
        w_pick_oh          = '0;
        w_pick_oh[w_pick]  = 1'b1;
        w_owner_oh         = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    // Select the owner's data word for the register load.
    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_owner == OwnerW'(i)) begin
                w_wdata = data[i*W +: W];
            end
        end
    end

`ifdef REG_SHARE_LOCK_EN
    assign w_lock_hold = lock[r_owner];
`else
    logic w_lock_unused;
    assign w_lock_unused = ^lock;
    assign w_lock_hold   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic; requests are not looked at in ACK.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_d = StGrant;
            StGrant: w_state_d = StAck;
            StAck:   w_state_d = w_lock_hold ? StGrant : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // FSM output logic: next values for the registered grant/ack/owner/ptr.
    always_comb begin
        w_gnt_d   = '0;
        w_ack_d   = '0;
        w_owner_d = r_owner;
        w_ptr_d   = r_ptr;
        w_load    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_gnt_d   = w_pick_oh;
                    w_owner_d = w_pick;
                end
            end
            StGrant: begin
                w_load  = 1'b1;
                w_ack_d = w_owner_oh;
                w_ptr_d = w_ptr_next;
            end
            StAck: begin
                // Burst hold re-grants the same owner; ptr is left untouched.
                if (w_lock_hold) begin
                    w_gnt_d = w_owner_oh;
                end
            end
            default: begin
                w_gnt_d = '0;
            end
        endcase
    end

    // Registered outputs and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= '0;
            r_ack   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_gnt   <= w_gnt_d;
            r_ack   <= w_ack_d;
            r_owner <= w_owner_d;
            r_ptr   <= w_ptr_d;
        end
    end

    reg_load_en #(
        .W (W)
    ) u_reg (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_load),
        .i_d     (w_wdata),
        .o_q     (q)
    );

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign owner = r_owner;
    assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level round-robin model.
// Honours REG_SHARE_LOCK_EN the same way the design does.
module tb_reg_share_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;
`ifdef REG_SHARE_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   data;
    logic [N-1:0]     lock;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic [W-1:0]     q;
    logic             busy;
    logic [1:0]       owner;

    int               checks;
    int               failures;
    int               m_ptr;
    logic [W-1:0]     dat [N];
    int               burst_left [N];
    int               grant_log [$];

    reg_share_arbiter #(
        .N (N),
        .W (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .lock  (lock),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        data = '0;
        for (int i = 0; i < N; i++) begin
            data[i*W +: W] = dat[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner rule: first requesting index at or above ptr, wrapping around.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_inv();
        chk("gnt_ack_excl", 32'(gnt & ack), 32'd0);
        chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
        chk("ack_onehot0", 32'($countones(ack) <= 1), 32'd1);
    endtask

    // One arbitration from IDLE, including any locked burst that follows.
    // Entered and left at posedge+1 with the DUT idle.
    task automatic write_one(input bit withdraw);
        int w;
        bit hold;
        bit done;
        w = model_pick(req, m_ptr);
        @(posedge clk); #1;
        chk("grant", 32'(gnt), 32'(1 << w));
        chk("grant_owner", 32'(owner), 32'(w));
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_no_ack", 32'(ack), 32'd0);
        if (withdraw) req[w] = 1'b0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            chk("ack", 32'(ack), 32'(1 << w));
            chk("q", 32'(q), 32'(dat[w]));
            chk("ack_gnt_low", 32'(gnt), 32'd0);
            chk("ack_busy", 32'(busy), 32'd1);
            chk_inv();
            grant_log.push_back(w);
            m_ptr = (w + 1) % N;
            if (burst_left[w] > 0) burst_left[w]--;
            lock[w] = (burst_left[w] > 0);
            hold = LockEn && lock[w];
            if (!hold) begin
                req[w]        = 1'b0;
                lock[w]       = 1'b0;
                burst_left[w] = 0;
            end else begin
                dat[w] = W'($urandom);
            end
            @(posedge clk); #1;
            if (!hold) begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_gnt", 32'(gnt), 32'd0);
                chk("idle_ack", 32'(ack), 32'd0);
                done = 1'b1;
            end else begin
                chk("regrant", 32'(gnt), 32'(1 << w));
                chk("regrant_owner", 32'(owner), 32'(w));
                chk("regrant_busy", 32'(busy), 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] fair_data [4];
        int           exp_seq [$];
        checks   = 0;
        failures = 0;
        m_ptr    = 0;
        rst      = 1'b0;
        req      = '0;
        lock     = '0;
        for (int i = 0; i < N; i++) begin
            dat[i]        = '0;
            burst_left[i] = 0;
        end

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b1;

        // Reset asserted while in GRANT clears everything at once; no ack follows.
        req    = 4'b0100;
        dat[2] = 4'h7;
        @(posedge clk); #1;
        chk("midrst_pre_gnt", 32'(gnt), 32'b0100);
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd0);
        req = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("midrst_no_ack", 32'(ack), 32'd0);
        end
        rst   = 1'b1;
        m_ptr = 0;

        // Fairness: all four requesting, each dropping on its own ack.
        fair_data[0] = 4'h3;
        fair_data[1] = 4'h5;
        fair_data[2] = 4'h9;
        fair_data[3] = 4'hF;
        for (int i = 0; i < N; i++) dat[i] = fair_data[i];
        req = 4'b1111;
        grant_log.delete();
        repeat (4) write_one(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("fair_order", 32'(grant_log[i]), 32'(i));
        end

        // Wrap-around: pointer after requester 3 is back at 0.
        req = 4'b1001;
        grant_log.delete();
        write_one(1'b0);
        chk("wrap_first", 32'(grant_log[0]), 32'd0);
        write_one(1'b0);
        chk("wrap_second", 32'(grant_log[1]), 32'd3);

        // Single request timing.
        req    = 4'b0001;
        dat[0] = 4'hA;
        write_one(1'b0);
        chk("single_q", 32'(q), 32'hA);

        // Late withdraw during GRANT still completes the write.
        req    = 4'b0010;
        dat[1] = 4'h6;
        write_one(1'b1);
        chk("withdraw_q", 32'(q), 32'h6);
        @(posedge clk); #1;
        chk("withdraw_no_regrant", 32'(gnt), 32'd0);
        chk("withdraw_idle", 32'(busy), 32'd0);

        // Burst lock on requester 2 with requester 1 waiting.
        req           = 4'b0110;
        burst_left[2] = 3;
        lock[2]       = 1'b1;
        grant_log.delete();
        while (req != '0) write_one(1'b0);
        if (LockEn) exp_seq = '{2, 2, 2, 1};
        else        exp_seq = '{2, 1};
        chk("lock_count", 32'(grant_log.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++) begin
            chk("lock_order", 32'(grant_log[i]), 32'(exp_seq[i]));
        end

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                dat[i]        = W'($urandom);
                burst_left[i] = (req[i] && $urandom_range(0, 3) == 0) ?
                                int'($urandom_range(1, 3)) : 0;
                lock[i]       = (burst_left[i] > 0);
            end
            if (req == '0) begin
                @(posedge clk); #1;
                chk("rand_idle_busy", 32'(busy), 32'd0);
                chk("rand_idle_gnt", 32'(gnt), 32'd0);
            end else begin
                while (req != '0) write_one($urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
